even_parity_fifo: RTL

EVEN_PARITY_FIFO -- requirements
Module: even_parity_fifo

---
 rtl/even_parity_fifo.sv | 79 +++++++
 1 files changed

// File: rtl/even_parity_fifo.sv
// Synchronous FIFO that stores an even-parity bit with every payload word.
// The head entry falls through to dout as {parity, payload}, and dout is forced to zero while the FIFO is empty.
module even_parity_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wn,
   input  logic                  rn,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  par_inject,
   output logic [DATA_WIDTH:0]   dout,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_W-1:0]      count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH:0] mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                overflow_q, overflow_d;
   logic                underflow_q, underflow_d;
   logic                wr_acc, rd_acc;
   logic [DATA_WIDTH:0] wr_entry;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign dout      = empty ? '0 : mem_q[rd_ptr_q];

   // Handshake: a write is accepted when there is room, or when the FIFO is full and a pop happens on the same edge.
   // A read is accepted whenever the FIFO holds data. A request that is not accepted raises a one-cycle flag.
   always_comb begin
      wr_acc      = wn && (!full || rn);
      rd_acc      = rn && !empty;
      wr_entry    = {(^din) ^ par_inject, din};
      wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d    = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
      overflow_d  = wn && !wr_acc;
      underflow_d = rn && !rd_acc;
      count_d     = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not reset; empty masks stale contents from dout.
   always_ff @(posedge clock) begin
      if (wr_acc) mem_q[wr_ptr_q] <= wr_entry;
   end

endmodule
